// File: rtl/vending_pkg.sv
// Shared definitions for the vending machine datapath: change codes, coin values
// and the payout controller state encoding.
package vending_pkg;

  localparam logic [1:0] CHG_NONE = 2'b00;
  localparam logic [1:0] CHG_5    = 2'b01;
  localparam logic [1:0] CHG_10   = 2'b10;
  localparam logic [1:0] CHG_5X2  = 2'b11;

  localparam int unsigned COIN_5_VALUE  = 32'd5;
  localparam int unsigned COIN_10_VALUE = 32'd10;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DISPENSE  = 3'd1,
    EJECT     = 3'd2,
    WAIT_COIN = 3'd3,
    FAULT     = 3'd4
  } payout_state_t;

  // Number of physical coins the hopper must release for a change code.
  function automatic logic [1:0] coins_for(input logic [1:0] chg);
    logic [1:0] n;
    case (chg)
      CHG_NONE: n = 2'd0;
      CHG_5X2:  n = 2'd2;
      default:  n = 2'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/payout_fifo.sv
// Small circular transaction buffer; a push into a full FIFO still succeeds when
// a pop frees the head slot in the same cycle.
module payout_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             pop_ok_s;
  logic             push_ok_s;

  assign pop_ok_s  = pop && (count_r != CNT_ZERO);
  assign push_ok_s = push && ((count_r != CNT_FULL) || pop_ok_s);

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= CNT_ZERO;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign full  = (count_r == CNT_FULL);
  assign empty = (count_r == CNT_ZERO);
  assign count = count_r;

endmodule

// File: rtl/vending_payout_ctrl.sv
// Queues sale/change transactions and drives the product motor and coin hopper
// one actuator at a time, waiting for sensor confirmation or a timeout.
module vending_payout_ctrl
  import vending_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int PULSE_W    = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       out,
  input  logic [1:0] change,
  output logic       motor_en,
  output logic       eject5,
  output logic       eject10,
  input  logic       drop_sense,
  input  logic       coin_sense,
  output logic       busy,
  output logic       overflow,
  output logic       fault
);

  localparam int         CW         = $clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0] PULSE_LAST = 8'(PULSE_W - 1);
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

  payout_state_t state_r;
  payout_state_t next_state_s;
  logic [1:0]    work_chg_r;
  logic [1:0]    coins_r;
  logic [7:0]    tmo_cnt_r;
  logic          early_r;
  logic          motor_en_r;
  logic          eject5_r;
  logic          eject10_r;
  logic          overflow_r;
  logic          fault_r;

  logic          push_s;
  logic          pop_s;
  logic          coin_dec_s;
  logic          early_set_s;
  logic          tmo_hit_s;
  logic [1:0]    chg_next_s;
  logic [2:0]    head_s;
  logic          full_s;
  logic          empty_s;
  logic [CW-1:0] count_s;

  assign push_s = out || (change != CHG_NONE);

  payout_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(3)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .wdata ({out, change}),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count_s)
  );

  assign tmo_hit_s  = (tmo_cnt_r == TMO_LAST);
  assign chg_next_s = pop_s ? head_s[1:0] : work_chg_r;

  // Next-state and pop decision for the actuator sequencer.
  always_comb begin
    next_state_s = state_r;
    pop_s        = 1'b0;
    coin_dec_s   = 1'b0;
    early_set_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s && !fault_r) begin
          pop_s = 1'b1;
          if (head_s[2]) begin
            next_state_s = DISPENSE;
          end else if (head_s[1:0] != CHG_NONE) begin
            next_state_s = EJECT;
          end else begin
            next_state_s = IDLE;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      DISPENSE: begin
        if (drop_sense) begin
          next_state_s = (work_chg_r != CHG_NONE) ? EJECT : IDLE;
        end else if (tmo_hit_s) begin
          next_state_s = FAULT;
        end else begin
          next_state_s = DISPENSE;
        end
      end
      EJECT: begin
        // A coin seen on the last pulse cycle is remembered and consumed in WAIT_COIN.
        if (tmo_cnt_r == PULSE_LAST) begin
          next_state_s = WAIT_COIN;
          early_set_s  = coin_sense;
        end else begin
          next_state_s = EJECT;
        end
      end
      WAIT_COIN: begin
        if (coin_sense || early_r) begin
          coin_dec_s   = 1'b1;
          next_state_s = (coins_r <= 2'd1) ? IDLE : EJECT;
        end else if (tmo_hit_s) begin
          next_state_s = FAULT;
        end else begin
          next_state_s = WAIT_COIN;
        end
      end
      FAULT:   next_state_s = FAULT;
      default: next_state_s = IDLE;
    endcase
  end

  // State, working transaction, counters and registered actuator outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      work_chg_r <= CHG_NONE;
      coins_r    <= 2'd0;
      tmo_cnt_r  <= 8'd0;
      early_r    <= 1'b0;
      motor_en_r <= 1'b0;
      eject5_r   <= 1'b0;
      eject10_r  <= 1'b0;
      overflow_r <= 1'b0;
      fault_r    <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (pop_s) begin
        work_chg_r <= head_s[1:0];
        coins_r    <= coins_for(head_s[1:0]);
      end else if (coin_dec_s) begin
        coins_r <= coins_r - 2'd1;
      end
      if (next_state_s != state_r) begin
        tmo_cnt_r <= 8'd0;
      end else if (tmo_cnt_r != 8'hFF) begin
        tmo_cnt_r <= tmo_cnt_r + 8'd1;
      end
      early_r    <= early_set_s;
      motor_en_r <= (next_state_s == DISPENSE);
      eject5_r   <= (next_state_s == EJECT) && (chg_next_s != CHG_10);
      eject10_r  <= (next_state_s == EJECT) && (chg_next_s == CHG_10);
      fault_r    <= (next_state_s == FAULT);
      if (push_s && full_s && !pop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign motor_en = motor_en_r;
  assign eject5   = eject5_r;
  assign eject10  = eject10_r;
  assign overflow = overflow_r;
  assign fault    = fault_r;
  assign busy     = (count_s != {CW{1'b0}}) || (state_r != IDLE);

endmodule

// File: tb/tb_vending_payout_ctrl.sv
// Directed bench for vending_payout_ctrl: sale, change rounds, FIFO ordering and
// overflow, sensor timeout and mid-eject reset.
module tb_vending_payout_ctrl;

  localparam int MOTOR = 0;
  localparam int EJ5   = 1;
  localparam int EJ10  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       out;
  logic [1:0] change;
  logic       drop_sense;
  logic       coin_sense;
  logic       motor_en;
  logic       eject5;
  logic       eject10;
  logic       busy;
  logic       overflow;
  logic       fault;

  int   vectors = 0;
  int   miscompares = 0;
  int   mot_cyc = 0;
  int   e5_cyc = 0;
  int   e10_cyc = 0;
  logic mon_clr;

  vending_payout_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .out        (out),
    .change     (change),
    .motor_en   (motor_en),
    .eject5     (eject5),
    .eject10    (eject10),
    .drop_sense (drop_sense),
    .coin_sense (coin_sense),
    .busy       (busy),
    .overflow   (overflow),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  // Actuator activity counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_clr) begin
      mot_cyc <= 0;
      e5_cyc  <= 0;
      e10_cyc <= 0;
    end else begin
      if (motor_en === 1'b1) mot_cyc <= mot_cyc + 1;
      if (eject5 === 1'b1)   e5_cyc  <= e5_cyc + 1;
      if (eject10 === 1'b1)  e10_cyc <= e10_cyc + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic act(input int sel);
    logic v;
    case (sel)
      MOTOR:   v = motor_en;
      EJ5:     v = eject5;
      EJ10:    v = eject10;
      default: v = 1'b0;
    endcase
    return v;
  endfunction

  // Wait for an actuator, answer with its sensor resp cycles after it is first seen high.
  task automatic actuate(input int sel, input int resp, input int exp_w, input string tag);
    int t;
    int hi;
    t = 0;
    while (act(sel) !== 1'b1 && t < 40) begin
      step();
      t++;
    end
    chk({tag, " rise"}, act(sel), 1'b1);
    hi = 0;
    for (int i = 0; i <= resp; i++) begin
      if (act(sel) === 1'b1) hi++;
      chk({tag, " onehot"}, ($countones({motor_en, eject5, eject10}) <= 1), 1'b1);
      if (i == resp) begin
        if (sel == MOTOR) drop_sense = 1'b1;
        else coin_sense = 1'b1;
      end
      step();
      drop_sense = 1'b0;
      coin_sense = 1'b0;
    end
    chk({tag, " width"}, hi, exp_w);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    step();
    mon_clr = 1'b0;
  endtask

  initial begin
    int t;
    int hi;
    rst = 1'b1;
    out = 1'b0;
    change = 2'b00;
    drop_sense = 1'b0;
    coin_sense = 1'b0;
    mon_clr = 1'b1;
    step();
    step();
    chk("reset motor_en", motor_en, 1'b0);
    chk("reset eject5", eject5, 1'b0);
    chk("reset eject10", eject10, 1'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset overflow", overflow, 1'b0);
    chk("reset fault", fault, 1'b0);
    rst = 1'b0;
    mon_clr = 1'b0;
    step();

    // Single sale: request in cycle 0, motor cycles 2..11, drop in cycle 11.
    out = 1'b1;
    step();
    out = 1'b0;
    chk("sale motor c1", motor_en, 1'b0);
    chk("sale busy c1", busy, 1'b1);
    step();
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      if (motor_en === 1'b1) hi++;
      if (i == 9) drop_sense = 1'b1;
      step();
      drop_sense = 1'b0;
    end
    chk("sale motor width", hi, 10);
    chk("sale motor off", motor_en, 1'b0);
    chk("sale busy off", busy, 1'b0);
    chk("sale no eject", eject5 | eject10, 1'b0);

    // Sale with two 5-unit coins.
    clear_mon();
    out = 1'b1;
    change = 2'b11;
    step();
    out = 1'b0;
    change = 2'b00;
    actuate(MOTOR, 3, 4, "x2 motor");
    actuate(EJ5, 6, 4, "x2 coin1");
    actuate(EJ5, 6, 4, "x2 coin2");
    chk("x2 busy", busy, 1'b0);
    chk("x2 e5 cycles", e5_cyc, 8);
    chk("x2 e10 cycles", e10_cyc, 0);

    // Change-only 10-unit coin.
    clear_mon();
    change = 2'b10;
    step();
    change = 2'b00;
    actuate(EJ10, 6, 4, "c10 eject");
    chk("c10 busy", busy, 1'b0);
    chk("c10 e10 cycles", e10_cyc, 4);
    chk("c10 motor cycles", mot_cyc, 0);

    // FIFO fill/overflow while A dispenses, then a push that meets a pop while full.
    out = 1'b1;
    step();
    out = 1'b0;
    step();
    chk("ovf A motor", motor_en, 1'b1);
    out = 1'b0; change = 2'b01; step();
    out = 1'b0; change = 2'b10; step();
    out = 1'b1; change = 2'b00; step();
    out = 1'b0; change = 2'b10; step();
    out = 1'b0; change = 2'b00;
    chk("ovf not yet", overflow, 1'b0);
    change = 2'b01;
    step();
    change = 2'b00;
    chk("ovf set", overflow, 1'b1);
    actuate(MOTOR, 2, 3, "ovf A");
    change = 2'b01;
    step();
    change = 2'b00;
    actuate(EJ5, 6, 4, "ovf B");
    actuate(EJ10, 6, 4, "ovf C");
    actuate(MOTOR, 3, 4, "ovf D");
    actuate(EJ10, 6, 4, "ovf E");
    actuate(EJ5, 6, 4, "ovf G");
    chk("ovf busy end", busy, 1'b0);
    chk("ovf sticky", overflow, 1'b1);

    // Drop sensor never arrives: 255 motor cycles then fault.
    do_reset();
    chk("tmo ovf cleared", overflow, 1'b0);
    out = 1'b1;
    step();
    out = 1'b0;
    t = 0;
    while (motor_en !== 1'b1 && t < 10) begin
      step();
      t++;
    end
    hi = 0;
    while (motor_en === 1'b1 && hi < 400) begin
      hi++;
      step();
    end
    chk("tmo motor width", hi, 255);
    chk("tmo fault", fault, 1'b1);
    chk("tmo motor off", motor_en, 1'b0);
    clear_mon();
    change = 2'b10;
    step();
    change = 2'b00;
    for (int i = 0; i < 10; i++) step();
    chk("tmo queued busy", busy, 1'b1);
    chk("tmo no exec", e10_cyc, 0);
    chk("tmo fault held", fault, 1'b1);

    // Reset during the second eject5 cycle with another sale queued.
    do_reset();
    chk("rst fault cleared", fault, 1'b0);
    change = 2'b01;
    step();
    change = 2'b00;
    out = 1'b1;
    step();
    out = 1'b0;
    chk("rst eject c1", eject5, 1'b1);
    step();
    chk("rst eject c2", eject5, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst eject5", eject5, 1'b0);
    chk("rst fault", fault, 1'b0);
    chk("rst overflow", overflow, 1'b0);
    chk("rst busy", busy, 1'b0);
    for (int i = 0; i < 4; i++) step();
    chk("rst queue dropped", motor_en, 1'b0);
    chk("rst still idle", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vending_payout_ctrl.md
Name: vending_payout_ctrl

Overview:
Downstream consumer of the vending machine's dispense/change outputs. Captures each transaction (product flag + change code) into a small FIFO and drives the product motor and coin hopper one actuator at a time. Each actuation waits for sensor confirmation or a timeout. Sits between the vending FSM outputs (out, change[1:0]) and the physical actuator drivers.

Parameters:
FIFO_DEPTH, 4, transaction buffer entries (power of 2, >=2)
PULSE_W, 4, hopper eject pulse width in clk cycles (>=1)
TIMEOUT, 255, max cycles waiting for a sensor before fault (8-bit counter range)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
out  input  1  dispense request from vending FSM, one-cycle pulse per sale
change  input  2  change code, valid with or without out: 00 none, 01 one 5-unit coin, 10 one 10-unit coin, 11 two 5-unit coins
motor_en  output  1  product motor drive, level
eject5  output  1  5-unit hopper eject pulse
eject10  output  1  10-unit hopper eject pulse
drop_sense  input  1  product-drop sensor, one-cycle pulse
coin_sense  input  1  coin-exit sensor, one-cycle pulse
busy  output  1  FIFO non-empty or FSM not IDLE
overflow  output  1  sticky: request arrived while FIFO full
fault  output  1  sticky: sensor timeout

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset: all outputs 0, FIFO empty, FSM in IDLE, counters 0. Reset mid-actuation drops motor_en and eject pulses on the next edge and discards queued entries.
- Capture: a transaction is {out, change}. It is pushed when out=1 or change!=00, in the same cycle it appears.
- If the FIFO is full, the request is dropped and overflow is set (sticky until rst).
- Push and pop in the same cycle while full: the pop frees the slot, so the push succeeds. Occupancy is unchanged and there is no overflow.
- FSM states: IDLE, DISPENSE, EJECT, WAIT_COIN, FAULT.
- IDLE:
  - If the FIFO is non-empty and fault=0, pop the head into a working register.
  - Next state is DISPENSE if the out bit is set, else EJECT if change!=00.
  - Pop-to-actuator latency is 1 cycle: motor_en or the first eject pulse rises the cycle after the pop.
- DISPENSE:
  - motor_en=1 and the timeout counter increments.
  - On drop_sense: motor_en=0 on the next cycle, then go to EJECT if change!=00, else IDLE.
  - If the counter reaches TIMEOUT: go to FAULT.
- EJECT:
  - Assert eject5 (codes 01, 11) or eject10 (code 10) for exactly PULSE_W cycles, then go to WAIT_COIN.
  - Code 11 performs two complete 5-unit EJECT/WAIT_COIN rounds; track this with a remaining-coin counter (2 bits).
- WAIT_COIN:
  - On coin_sense: decrement the remaining count. If it reaches 0, go to IDLE; else go back to EJECT.
  - If the counter reaches TIMEOUT: go to FAULT.
  - coin_sense that coincides with the final PULSE_W cycle is accepted (counts as confirmation).
- Timeout counter: cleared on every state entry; 8-bit saturating.
- FAULT:
  - All actuators 0 and fault=1.
  - Stays in FAULT until rst; the FIFO keeps accepting requests until full.
- Unexpected sensors: sensor pulses in IDLE or EJECT (other than the final-cycle case above) are ignored.
- Ordering: at most one actuator is asserted in any cycle; eject5 and eject10 are never high together.
- busy is combinational from FIFO count and state.

Decomposition:
- Shared package vending_pkg holds:
  - change-code constants CHG_NONE, CHG_5, CHG_10, CHG_5X2
  - payout state enum
  - coin value constants, shared with the vending FSM
- One natural sub-module: payout_fifo. Parameterised depth, width 3, with push/pop/full/empty/count and simultaneous push+pop support when full.

Test Plan:
- Single sale, out=1 with change=00 for 1 cycle, drop_sense 10 cycles later -> motor_en high for 10 cycles starting 2 cycles after the request (1-cycle capture + 1-cycle pop latency), no ejects, busy falls after the return to IDLE.
- Sale with change=11, sensors respond 3 cycles after each pulse -> motor phase, then eject5 high 4 cycles, coin_sense, eject5 high 4 cycles again, coin_sense, return to IDLE; eject10 never asserted.
- Change-only 10, change=10 with out=0 -> no motor_en, eject10 pulse of exactly PULSE_W=4 cycles, IDLE after coin_sense.
- Back-to-back 5 requests while the first transaction is still in DISPENSE -> 4 queued, overflow=1 on the 5th, transactions executed in FIFO order.
- Timeout: out=1 and no drop_sense -> motor_en drops and fault=1 after 255 cycles; later requests are queued but not executed.
- Reset mid-eject: rst during the 2nd cycle of eject5 -> next edge eject5=0, fault=0, overflow=0, busy=0.
